// File: rtl/psram_pkg.sv
// Shared constants for the PSRAM arbiter: FSM state codes, controller size/command
// codes and the default watchdog length.
package psram_pkg;
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    localparam logic [2:0] PSRAM_SIZE_WORD = 3'b010;
    localparam logic [7:0] PSRAM_CMD_QREAD = 8'hEB;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/psram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit starting at rr_ptr, wrapping
// modulo NUM_REQ. Outputs both one-hot and encoded forms of the winner.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx
);
    logic found;

    always_comb begin
        int j;
        j     = 0;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller among NUM_REQ requesters; one
// transaction in flight, with a watchdog that forces an error completion.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rd_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*3-1:0]          req_size,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         ctrl_addr,
    output logic [DATA_WIDTH-1:0]         ctrl_data_i,
    output logic [2:0]                    ctrl_size,
    output logic                          ctrl_rd_wr,
    output logic                          ctrl_start,
    input  logic [DATA_WIDTH-1:0]         ctrl_data_o,
    input  logic                          ctrl_done
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [1:0]         state, next_state;
    logic [IDX_W-1:0]   rr_ptr, gnt_idx, pick_idx;
    logic [NUM_REQ-1:0] pick;
    logic [TMR_W-1:0]   timer;
    logic               timeout, grant_now, complete;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .idx    (pick_idx)
    );

    assign timeout = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:  if (|req) next_state = ARB_ISSUE;
            ARB_ISSUE: next_state = ARB_WAIT;
            ARB_WAIT:  if (ctrl_done || timeout) next_state = ARB_RESP;
            ARB_RESP:  next_state = ARB_IDLE;
            default:   next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ARB_IDLE);
        grant_now = (state == ARB_IDLE) && (|req);
        complete  = (state == ARB_WAIT) && (ctrl_done || timeout);
    end

    // ctrl_start and rsp_valid are registered so they line up with ISSUE/RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt         <= '0;
            gnt_idx     <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            ctrl_addr   <= '0;
            ctrl_data_i <= '0;
            ctrl_size   <= PSRAM_SIZE_WORD;
            ctrl_rd_wr  <= 1'b0;
            ctrl_start  <= 1'b0;
        end else begin
            ctrl_start <= grant_now;
            rsp_valid  <= complete ? gnt : '0;
            case (state)
                ARB_IDLE: if (grant_now) begin
                    ctrl_addr   <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    ctrl_data_i <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    ctrl_size   <= req_size[pick_idx*3 +: 3];
                    ctrl_rd_wr  <= req_rd_wr[pick_idx];
                    gnt         <= pick;
                    gnt_idx     <= pick_idx;
                end
                ARB_ISSUE: timer <= '0;
                ARB_WAIT: begin
                    timer <= timer + 1'b1;
                    // done takes priority over a coincident timeout
                    if (ctrl_done) begin
                        if (ctrl_rd_wr) rsp_rdata <= ctrl_data_o;
                        rsp_err <= 1'b0;
                    end else if (timeout) begin
                        rsp_err <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    gnt    <= '0;
                    rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single EF_PSRAM_CTRL_V2 instance between NUM_REQ requesters.
- Typical requesters: conv weight/bias loader, result writer, host/Wishbone bridge.
- Arbitration is round-robin. The block issues one controller transaction at a time with a one-cycle start pulse, waits for done, and returns read data to the granted requester.
- A timeout watchdog guarantees forward progress if the controller never asserts done.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 24, PSRAM byte address width
- DATA_WIDTH, 32, controller data width
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before error completion (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester request, level
- req_rd_wr  in  NUM_REQ  1=read, 0=write, per requester
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_size  in  NUM_REQ*3  packed size codes (3'b010 = 4 bytes)
- gnt  out  NUM_REQ  one-hot, high from ISSUE through RESP
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid, 1 = timeout
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- busy  out  1  state != IDLE
- ctrl_addr  out  ADDR_WIDTH  to controller addr
- ctrl_data_i  out  DATA_WIDTH  to controller data_i
- ctrl_size  out  3  to controller size
- ctrl_rd_wr  out  1  to controller rd_wr
- ctrl_start  out  1  to controller start
- ctrl_data_o  in  DATA_WIDTH  from controller data_o
- ctrl_done  in  1  from controller done

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; gnt, rsp_valid=0; rsp_err=0; rsp_rdata=0; ctrl_*=0 except ctrl_size=3'b010; busy=0; rr_ptr=0; timer=0.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, if any req bit is set: select the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. Latch the selected addr, wdata, size and rd_wr into the ctrl_* registers, set gnt one-hot, go to ISSUE.
- ISSUE: ctrl_start=1 for exactly this cycle; clear timer; go to WAIT. ctrl_done is ignored in ISSUE.
- WAIT: ctrl_start=0; timer increments each cycle.
  - On ctrl_done: latch ctrl_data_o into rsp_rdata (reads only; writes leave rsp_rdata unchanged), rsp_err=0, go to RESP.
  - If timer reaches TIMEOUT_CYCLES-1 without done: rsp_err=1, rsp_rdata unchanged, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP: rsp_valid=gnt for one cycle; rr_ptr = granted index + 1 modulo NUM_REQ; gnt clears on the next cycle; go to IDLE.
- Latency: req sampled in IDLE at cycle T -> ctrl_start at T+1. ctrl_done at cycle D -> rsp_valid at D+1. Minimum back-to-back spacing is 4 cycles plus controller latency.
- Handshake: a requester holds req and its fields stable until its rsp_valid. Fields are latched at grant, so changes after grant are ignored. If req is dropped after grant, the transaction still completes and rsp_valid still pulses. Requesters must sample on rsp_valid.
- Fairness: a requester granted last has lowest priority next; no requester waits more than NUM_REQ-1 transactions.
- Only the ctrl_* registers drive the controller. The PSRAM pins remain at the controller instance.
- Synchronous rst mid-transaction returns to IDLE immediately and drops ctrl_start. No rsp_valid is issued for the aborted transaction. The controller is reset by the same rst.

Decomposition:
- Shared package psram_pkg holds:
  - state encoding localparams (ARB_IDLE=0, ARB_ISSUE=1, ARB_WAIT=2, ARB_RESP=3)
  - PSRAM_SIZE_WORD=3'b010, PSRAM_CMD_QREAD=8'hEB
  - default TIMEOUT_CYCLES
- One sub-module: rr_picker, purely combinational. Inputs req and rr_ptr; outputs one-hot pick and encoded index.

Test Plan:
- Single read: only req[1]=1, read, addr=24'h000100. Required: ctrl_start one cycle later with ctrl_addr=24'h000100; controller model returns done with 32'hDEADBEEF after 20 cycles; rsp_valid=3'b010 the next cycle, rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Round-robin: req=3'b111 held continuously, each served with 5-cycle done. Required: grant order 0,1,2,0,1,2, with exactly one ctrl_start per transaction.
- Write path: req[2] write, wdata=32'h0000ABCD, addr=24'h000200. Required: ctrl_rd_wr=0, ctrl_data_i=32'h0000ABCD, ctrl_size=3'b010; rsp_rdata unchanged after completion.
- Timeout: TIMEOUT_CYCLES=16, controller never asserts done. Required: rsp_valid with rsp_err=1 exactly 16 cycles after entering WAIT, then the next requester is served.
- Drop after grant: req[0] deasserted in WAIT, then done arrives. Required: rsp_valid[0] still pulses once and the arbiter returns to IDLE.
- Reset mid-WAIT: rst=1 for one cycle during WAIT. Required: gnt=0, busy=0, ctrl_start=0, no rsp_valid; a new request is served normally starting from rr_ptr=0.
